// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage (port 0) vs loader/DMA (port 1), fixed CPU priority with loader aging.
// Optional macro DMEM_ARB_LOCK_EN adds dma_lock so the loader can hold the memory across consecutive accesses.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          dma_lock,
`endif
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt;
    logic              lock_act;
    logic              issue_rd;
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] id_p;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r <= 1'b0;
        end else if (dma_gnt && dma_lock) begin
            lock_r <= 1'b1;
        end else if (!dma_req || !dma_lock) begin
            lock_r <= 1'b0;
        end
    end

    assign lock_act = lock_r;
`else
    assign lock_act = 1'b0;
`endif

    // A held lock keeps the loader granted and shuts the CPU out entirely.
    always_comb begin
        dma_gnt   = dma_req & (~cpu_req | (wait_cnt == WAIT_MAX) | lock_act);
        cpu_gnt   = cpu_req & ~dma_gnt & ~lock_act;
        cpu_stall = cpu_req & ~cpu_gnt;
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (dma_gnt) begin
            mem_read  = ~dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_din   = dma_wdata;
        end else if (cpu_gnt) begin
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_din   = cpu_wdata;
        end
    end

    assign issue_rd = mem_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (dma_gnt || !dma_req) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Stage p0..p(RD_LAT-1): tag travels alongside the memory access; the last stage lines up with mem_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        id_p[0] <= dma_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            id_p[i] <= id_p[i-1];
        end
    end

    // Return stage: capture mem_dout into the owning port; rdata holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= vld_p[RD_LAT-1] & ~id_p[RD_LAT-1];
            dma_rvalid <= vld_p[RD_LAT-1] &  id_p[RD_LAT-1];
            if (vld_p[RD_LAT-1] && !id_p[RD_LAT-1]) begin
                cpu_rdata <= mem_dout;
            end
            if (vld_p[RD_LAT-1] && id_p[RD_LAT-1]) begin
                dma_rdata <= mem_dout;
            end
        end
    end

endmodule
